// File: rtl/gate_vector_checker_if.sv
// Bundle between gate_vector_checker (master) and the stimulus/response side it exercises (slave).
// start is a level request. The checker samples it only when it is idle or done, so a start seen while busy is dropped.
interface gate_vector_checker_if #(
    parameter int ERR_W = 8
);
    logic             start;
    logic             a;
    logic             b;
    logic             and_gate;
    logic             or_gate;
    logic             not_gate;
    logic             nand_gate;
    logic             nor_gate;
    logic             xor_gate;
    logic             xnor_gate;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_count;
    logic [1:0]       fail_vec;
    logic [6:0]       fail_mask;

    modport master (
        input  start, and_gate, or_gate, not_gate, nand_gate, nor_gate, xor_gate, xnor_gate,
        output a, b, busy, done, pass, err_count, fail_vec, fail_mask
    );

    modport slave (
        output start, and_gate, or_gate, not_gate, nand_gate, nor_gate, xor_gate, xnor_gate,
        input  a, b, busy, done, pass, err_count, fail_vec, fail_mask
    );
endinterface

// File: rtl/gate_vector_checker.sv
// Sweeps {a,b} over 00..11 for NUM_PASSES passes, checks seven gate outputs against a golden model and reports the result.
// Optional feature: define GATE_CHK_STOP_ON_FAIL_EN to end the sweep at the first mismatching vector.
module gate_vector_checker #(
    parameter int SETTLE_CYCLES = 1,
    parameter int NUM_PASSES    = 1,
    parameter int ERR_W         = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    gate_vector_checker_if.master  chk_if,
    output logic [1:0]             state_o
);
    localparam int SC_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int PC_W = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_CHECK  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       vec_q, vec_d;
    logic [PC_W-1:0]  pass_cnt_q, pass_cnt_d;
    logic [SC_W-1:0]  settle_q, settle_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [1:0]       fail_vec_q, fail_vec_d;
    logic [6:0]       fail_mask_q, fail_mask_d;
    logic             pass_q, pass_d;

    logic [6:0] expected;
    logic [6:0] observed;
    logic [6:0] diff;
    logic       mismatch;
    logic       last_vec;
    logic       finish;
    logic       start_ok;

    // Golden responses, bit6..0 = {and,or,not,nand,nor,xor,xnor}
    assign expected = {vec_q[1] & vec_q[0], vec_q[1] | vec_q[0], ~vec_q[1],
                       ~(vec_q[1] & vec_q[0]), ~(vec_q[1] | vec_q[0]),
                       vec_q[1] ^ vec_q[0], ~(vec_q[1] ^ vec_q[0])};
    assign observed = {chk_if.and_gate, chk_if.or_gate, chk_if.not_gate, chk_if.nand_gate,
                       chk_if.nor_gate, chk_if.xor_gate, chk_if.xnor_gate};
    assign diff     = expected ^ observed;
    assign mismatch = |diff;
    assign last_vec = (vec_q == 2'b11) && (pass_cnt_q == PC_W'(NUM_PASSES - 1));
    assign start_ok = chk_if.start && ((state_q == S_IDLE) || (state_q == S_DONE));

`ifdef GATE_CHK_STOP_ON_FAIL_EN
    assign finish = last_vec || mismatch;
`else
    assign finish = last_vec;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (start_ok) state_d = S_SETTLE;
            S_SETTLE:       if (settle_q == '0) state_d = S_CHECK;
            S_CHECK:        state_d = finish ? S_DONE : S_SETTLE;
            default:        state_d = S_IDLE;
        endcase
    end

    always_comb begin
        chk_if.busy = (state_q == S_SETTLE) || (state_q == S_CHECK);
        chk_if.done = (state_q == S_DONE);
        state_o     = state_q;
    end

    always_comb begin
        vec_d       = vec_q;
        pass_cnt_d  = pass_cnt_q;
        settle_d    = settle_q;
        err_d       = err_q;
        fail_vec_d  = fail_vec_q;
        fail_mask_d = fail_mask_q;
        pass_d      = pass_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_ok) begin
                    vec_d       = 2'b00;
                    pass_cnt_d  = '0;
                    settle_d    = SC_W'(SETTLE_CYCLES - 1);
                    err_d       = '0;
                    fail_vec_d  = 2'b00;
                    fail_mask_d = 7'd0;
                    pass_d      = 1'b0;
                end
            end
            S_SETTLE: begin
                if (settle_q != '0) settle_d = settle_q - SC_W'(1);
            end
            S_CHECK: begin
                // One count per failing vector, saturating
                if (mismatch) begin
                    if (err_q != '1) err_d = err_q + ERR_W'(1);
                    fail_vec_d  = vec_q;
                    fail_mask_d = diff;
                end
                if (finish) begin
                    pass_d = (err_d == '0);
                end else begin
                    vec_d    = vec_q + 2'd1;
                    settle_d = SC_W'(SETTLE_CYCLES - 1);
                    if (vec_q == 2'b11) pass_cnt_d = pass_cnt_q + PC_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_q       <= 2'b00;
            pass_cnt_q  <= '0;
            settle_q    <= '0;
            err_q       <= '0;
            fail_vec_q  <= 2'b00;
            fail_mask_q <= 7'd0;
            pass_q      <= 1'b0;
        end else begin
            vec_q       <= vec_d;
            pass_cnt_q  <= pass_cnt_d;
            settle_q    <= settle_d;
            err_q       <= err_d;
            fail_vec_q  <= fail_vec_d;
            fail_mask_q <= fail_mask_d;
            pass_q      <= pass_d;
        end
    end

    assign chk_if.a         = vec_q[1];
    assign chk_if.b         = vec_q[0];
    assign chk_if.pass      = pass_q;
    assign chk_if.err_count = err_q;
    assign chk_if.fail_vec  = fail_vec_q;
    assign chk_if.fail_mask = fail_mask_q;
endmodule

// File: tb/tb_gate_vector_checker.sv
// Bench for gate_vector_checker: two instances (default sizing and a long, narrow-counter sizing) driven by faultable gate models.
module tb_gate_vector_checker;
    localparam int S0 = 1, P0 = 1, W0 = 8;
    localparam int S1 = 2, P1 = 3, W1 = 2;

    logic       clk;
    logic       rst_n;
    logic       start_r;
    logic [1:0] state0, state1;
    logic [6:0] mask0 [4];
    logic [6:0] mask1 [4];
    logic [6:0] g0, g1;
    int         n_tests;
    int         n_fail;

    gate_vector_checker_if #(.ERR_W(W0)) if0 ();
    gate_vector_checker_if #(.ERR_W(W1)) if1 ();

    gate_vector_checker #(.SETTLE_CYCLES(S0), .NUM_PASSES(P0), .ERR_W(W0)) u0 (
        .clk(clk), .rst_n(rst_n), .chk_if(if0), .state_o(state0));
    gate_vector_checker #(.SETTLE_CYCLES(S1), .NUM_PASSES(P1), .ERR_W(W1)) u1 (
        .clk(clk), .rst_n(rst_n), .chk_if(if1), .state_o(state1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Healthy logic_gates behaviour, bit6..0 = {and,or,not,nand,nor,xor,xnor}
    function automatic logic [6:0] gold(input logic [1:0] ab);
        logic a, b;
        a = ab[1];
        b = ab[0];
        return {a & b, a | b, ~a, ~(a & b), ~(a | b), a ^ b, ~(a ^ b)};
    endfunction

    always_comb g0 = gold({if0.a, if0.b}) ^ mask0[{if0.a, if0.b}];
    always_comb g1 = gold({if1.a, if1.b}) ^ mask1[{if1.a, if1.b}];
    assign {if0.and_gate, if0.or_gate, if0.not_gate, if0.nand_gate,
            if0.nor_gate, if0.xor_gate, if0.xnor_gate} = g0;
    assign {if1.and_gate, if1.or_gate, if1.not_gate, if1.nand_gate,
            if1.nor_gate, if1.xor_gate, if1.xnor_gate} = g1;
    assign if0.start = start_r;
    assign if1.start = start_r;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected sweep outcome from the fault table: the diff of a vector is simply its fault mask.
    task automatic predict(input logic [6:0] m [4], input int s, input int p, input int w,
                           output int l, output int err, output logic [1:0] fv,
                           output logic [6:0] fm, output logic ok, output logic [1:0] last_ab);
        int cnt;
        int maxv;
        bit stopped;
        cnt = 0; fv = 2'b00; fm = 7'd0; stopped = 1'b0;
        l = 4 * p * (s + 1);
        last_ab = 2'b11;
        for (int pi = 0; pi < p; pi++) begin
            for (int v = 0; v < 4; v++) begin
                if (!stopped && m[v] != 7'd0) begin
                    cnt++;
                    fv = 2'(v);
                    fm = m[v];
`ifdef GATE_CHK_STOP_ON_FAIL_EN
                    stopped = 1'b1;
                    l = (pi * 4 + v + 1) * (s + 1);
                    last_ab = 2'(v);
`endif
                end
            end
        end
        maxv = (1 << w) - 1;
        err = (cnt > maxv) ? maxv : cnt;
        ok = (cnt == 0);
    endtask

    task automatic check_unit(input string nm, input int n, input int l, input int s,
                              input logic [1:0] ab, input logic busy, input logic done,
                              input logic pass, input logic [7:0] err, input logic [1:0] fv,
                              input logic [6:0] fm, input int e_err, input logic [1:0] e_fv,
                              input logic [6:0] e_fm, input logic e_ok, input logic [1:0] e_last);
        if (n < l) begin
            check($sformatf("%s_ab_n%0d", nm, n), 32'(ab), 32'((n / (s + 1)) % 4));
            check($sformatf("%s_busy_n%0d", nm, n), 32'(busy), 32'd1);
            check($sformatf("%s_done_n%0d", nm, n), 32'(done), 32'd0);
            if (n == 0) begin
                check($sformatf("%s_clr_err", nm), 32'(err), 32'd0);
                check($sformatf("%s_clr_fv", nm), 32'(fv), 32'd0);
                check($sformatf("%s_clr_fm", nm), 32'(fm), 32'd0);
                check($sformatf("%s_clr_pass", nm), 32'(pass), 32'd0);
            end
        end else begin
            check($sformatf("%s_done_n%0d", nm, n), 32'(done), 32'd1);
            check($sformatf("%s_busy_n%0d", nm, n), 32'(busy), 32'd0);
            if (n == l) begin
                check($sformatf("%s_pass", nm), 32'(pass), 32'(e_ok));
                check($sformatf("%s_err", nm), 32'(err), 32'(e_err));
                check($sformatf("%s_fail_vec", nm), 32'(fv), 32'(e_fv));
                check($sformatf("%s_fail_mask", nm), 32'(fm), 32'(e_fm));
                check($sformatf("%s_last_ab", nm), 32'(ab), 32'(e_last));
            end
        end
    endtask

    // Start at edge k, optionally poke start again while both units are busy, follow both until done.
    task automatic run_sweep(input int poke_n);
        int l0, l1, e0, e1, lmax, poke;
        logic [1:0] fv0, fv1, la0, la1;
        logic [6:0] fm0, fm1;
        logic ok0, ok1;
        predict(mask0, S0, P0, W0, l0, e0, fv0, fm0, ok0, la0);
        predict(mask1, S1, P1, W1, l1, e1, fv1, fm1, ok1, la1);
        poke = (poke_n < ((l0 < l1) ? l0 : l1) - 1) ? poke_n : -1;
        lmax = ((l0 > l1) ? l0 : l1) + 2;
        start_r = 1'b1;
        @(posedge clk);
        #1;
        for (int n = 0; n <= lmax; n++) begin
            if (n > 0) begin
                @(posedge clk);
                #1;
            end
            start_r = (n == poke);
            check_unit("u0", n, l0, S0, {if0.a, if0.b}, if0.busy, if0.done, if0.pass,
                       8'(if0.err_count), if0.fail_vec, if0.fail_mask, e0, fv0, fm0, ok0, la0);
            check_unit("u1", n, l1, S1, {if1.a, if1.b}, if1.busy, if1.done, if1.pass,
                       8'(if1.err_count), if1.fail_vec, if1.fail_mask, e1, fv1, fm1, ok1, la1);
        end
        start_r = 1'b0;
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, "_u0_outs"}, 32'({if0.a, if0.b, if0.busy, if0.done, if0.pass}), 32'd0);
        check({nm, "_u0_err"}, 32'(if0.err_count), 32'd0);
        check({nm, "_u0_fail"}, 32'({if0.fail_vec, if0.fail_mask}), 32'd0);
        check({nm, "_u0_state"}, 32'(state0), 32'd0);
        check({nm, "_u1_outs"}, 32'({if1.a, if1.b, if1.busy, if1.done, if1.pass}), 32'd0);
        check({nm, "_u1_err"}, 32'(if1.err_count), 32'd0);
        check({nm, "_u1_fail"}, 32'({if1.fail_vec, if1.fail_mask}), 32'd0);
        check({nm, "_u1_state"}, 32'(state1), 32'd0);
    endtask

    task automatic set_masks(input logic [6:0] a0, b0, c0, d0, input logic [6:0] a1, b1, c1, d1);
        mask0[0] = a0; mask0[1] = b0; mask0[2] = c0; mask0[3] = d0;
        mask1[0] = a1; mask1[1] = b1; mask1[2] = c1; mask1[3] = d1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        start_r = 1'b0;
        set_masks(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("idle_no_start");

        run_sweep(-1);

        // u0: xor stuck at 0 fails 01 and 10; u1: every output inverted, counter saturates
        set_masks(0, 7'b0000010, 7'b0000010, 0, 7'h7f, 7'h7f, 7'h7f, 7'h7f);
        run_sweep(3);

        // Reset three cycles into a sweep with u0 already holding an error
        set_masks(7'h7f, 7'h7f, 7'h7f, 7'h7f, 0, 0, 0, 0);
        start_r = 1'b1;
        @(posedge clk);
        #1;
        start_r = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("midrst_pre_ab", 32'({if0.a, if0.b}), 32'd1);
        check("midrst_pre_err", 32'(if0.err_count), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        set_masks(0, 0, 0, 0, 0, 0, 0, 0);
        run_sweep(-1);

        for (int t = 0; t < 8; t++) begin
            for (int v = 0; v < 4; v++) begin
                mask0[v] = ($urandom_range(0, 1) == 1) ? 7'($urandom_range(1, 127)) : 7'd0;
                mask1[v] = ($urandom_range(0, 2) == 0) ? 7'($urandom_range(1, 127)) : 7'd0;
            end
            run_sweep(($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 5)) : -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
